// File: rtl/genstore_pkg.sv
// Shared types for the multi-channel read-filter controller.
// Channel FSM states, filter modes and verdict encoding.
package genstore_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      HASH,
      DECIDE,
      CHAIN_REQ,
      CHAIN_WAIT,
      EMIT
   } ch_state_t;

   localparam logic MODE_EM = 1'b0;
   localparam logic MODE_MP = 1'b1;

   localparam logic VERDICT_DROP = 1'b0;
   localparam logic VERDICT_SEND = 1'b1;

endpackage

// File: rtl/genstore_ch_fsm.sv
// Per-channel read-filter FSM: fetch, hash lookup, verdict,
// optional chaining, then hold the verdict until the host accepts it.
module genstore_ch_fsm
   import genstore_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] thr_hi,
   input  logic [CNT_W-1:0] thr_lo,
   input  logic             rd_valid,
   output logic             rd_ready,
   output logic             hash_req,
   input  logic             hash_done,
   input  logic [CNT_W-1:0] seed_hits,
   output logic             chain_req,
   input  logic             grant,
   input  logic             chain_done,
   input  logic             chain_found,
   output logic             out_valid,
   output logic             out_send,
   input  logic             out_ready
);

   ch_state_t        r_state;
   logic             r_mode;
   logic [CNT_W-1:0] r_hits;
   logic             r_rd_ready;
   logic             r_hash_req;
   logic             r_chain_req;
   logic             r_out_valid;
   logic             r_out_send;
   logic             w_chain;
   logic             w_send;

   // thr_hi is tested first, so an inverted threshold pair leaves no chain band
   always_comb begin
      w_chain = 1'b0;
      w_send  = VERDICT_DROP;
      if (r_mode == MODE_MP) begin
         w_send = (r_hits != '0);
      end else if (r_hits >= thr_hi) begin
         w_send = VERDICT_SEND;
      end else if (r_hits >= thr_lo) begin
         w_chain = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mode      <= MODE_EM;
         r_hits      <= '0;
         r_rd_ready  <= 1'b0;
         r_hash_req  <= 1'b0;
         r_chain_req <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_send  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (en) begin
               r_state    <= READ;
               r_rd_ready <= 1'b1;
            end
            READ: if (rd_valid) begin
               r_state    <= HASH;
               r_rd_ready <= 1'b0;
               r_hash_req <= 1'b1;
               r_mode     <= mode;
            end
            HASH: if (hash_done) begin
               r_state    <= DECIDE;
               r_hash_req <= 1'b0;
               r_hits     <= seed_hits;
            end
            DECIDE: if (w_chain) begin
               r_state     <= CHAIN_REQ;
               r_chain_req <= 1'b1;
            end else begin
               r_state     <= EMIT;
               r_out_valid <= 1'b1;
               r_out_send  <= w_send;
            end
            CHAIN_REQ: if (grant) begin
               r_chain_req <= 1'b0;
               if (chain_done) begin
                  r_state     <= EMIT;
                  r_out_valid <= 1'b1;
                  r_out_send  <= chain_found;
               end else begin
                  r_state <= CHAIN_WAIT;
               end
            end
            CHAIN_WAIT: if (chain_done) begin
               r_state     <= EMIT;
               r_out_valid <= 1'b1;
               r_out_send  <= chain_found;
            end
            EMIT: if (out_ready) begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_out_send  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rd_ready  = r_rd_ready;
   assign hash_req  = r_hash_req;
   assign chain_req = r_chain_req;
   assign out_valid = r_out_valid;
   assign out_send  = r_out_send;

endmodule

// File: rtl/genstore_filter_ctrl.sv
// Multi-channel read filter: per-channel FSMs, round-robin grant of
// the shared chaining unit, and saturating forward/drop statistics.
module genstore_filter_ctrl
   import genstore_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int STAT_W = 32,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [CNT_W-1:0]        thr_hi,
   input  logic [CNT_W-1:0]        thr_lo,
   input  logic [NUM_CH-1:0]       rd_valid,
   output logic [NUM_CH-1:0]       rd_ready,
   output logic [NUM_CH-1:0]       hash_req,
   input  logic [NUM_CH-1:0]       hash_done,
   input  logic [NUM_CH*CNT_W-1:0] seed_hits,
   output logic                    chain_start,
   output logic [CH_W-1:0]         chain_ch,
   input  logic                    chain_done,
   input  logic                    chain_found,
   output logic [NUM_CH-1:0]       out_valid,
   output logic [NUM_CH-1:0]       out_send,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [STAT_W-1:0]       sent_cnt,
   output logic [STAT_W-1:0]       drop_cnt
);

   localparam int PW = $clog2(NUM_CH + 1);
   localparam logic [STAT_W+PW-1:0] SAT = {{PW{1'b0}}, {STAT_W{1'b1}}};

   logic [NUM_CH-1:0]    w_req;
   logic [NUM_CH-1:0]    w_grant;
   logic                 w_done;
   logic                 w_found;
   logic [CH_W-1:0]      w_pick;
   logic [PW-1:0]        w_n_send;
   logic [PW-1:0]        w_n_drop;
   logic [STAT_W+PW-1:0] w_sent_sum;
   logic [STAT_W+PW-1:0] w_drop_sum;
   logic                 r_busy;
   logic                 r_start;
   logic [CH_W-1:0]      r_ch;
   logic [CH_W-1:0]      r_ptr;
   logic [STAT_W-1:0]    r_sent;
   logic [STAT_W-1:0]    r_drop;

   // a done with no chain outstanding is dropped here
   assign w_done = chain_done & r_busy;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic w_sel;
         assign w_sel       = (r_ch == CH_W'(gi));
         assign w_grant[gi] = r_start & w_sel;
         genstore_ch_fsm #(.CNT_W(CNT_W)) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .mode        (mode),
            .thr_hi      (thr_hi),
            .thr_lo      (thr_lo),
            .rd_valid    (rd_valid[gi]),
            .rd_ready    (rd_ready[gi]),
            .hash_req    (hash_req[gi]),
            .hash_done   (hash_done[gi]),
            .seed_hits   (seed_hits[gi*CNT_W +: CNT_W]),
            .chain_req   (w_req[gi]),
            .grant       (w_grant[gi]),
            .chain_done  (w_done & w_sel),
            .chain_found (chain_found),
            .out_valid   (out_valid[gi]),
            .out_send    (out_send[gi]),
            .out_ready   (out_ready[gi])
         );
      end
   endgenerate

   always_comb begin : arb
      int idx;
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!w_found && w_req[idx[CH_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      w_n_send = '0;
      w_n_drop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (out_valid[i] && out_ready[i]) begin
            if (out_send[i]) w_n_send = w_n_send + PW'(1);
            else             w_n_drop = w_n_drop + PW'(1);
         end
      end
      w_sent_sum = {{PW{1'b0}}, r_sent} + {{STAT_W{1'b0}}, w_n_send};
      w_drop_sum = {{PW{1'b0}}, r_drop} + {{STAT_W{1'b0}}, w_n_drop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_start <= 1'b0;
         r_ch    <= '0;
         r_ptr   <= '0;
      end else begin
         r_start <= 1'b0;
         if (w_done) begin
            r_busy <= 1'b0;
         end else if (!r_busy && w_found) begin
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_ch    <= w_pick;
            r_ptr   <= (w_pick == CH_W'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sent <= '0;
         r_drop <= '0;
      end else begin
         r_sent <= (w_sent_sum > SAT) ? '1 : w_sent_sum[STAT_W-1:0];
         r_drop <= (w_drop_sum > SAT) ? '1 : w_drop_sum[STAT_W-1:0];
      end
   end

   assign chain_start = r_start;
   assign chain_ch    = r_ch;
   assign sent_cnt    = r_sent;
   assign drop_cnt    = r_drop;

endmodule
